// File: rtl/seg_digit_loader_if.sv
// Write-side bus of the digit loader: nibble writes, bank clear, ready handshake and
// the auto-increment pointer returned to the writer.
interface seg_digit_loader_if;
    logic       wr_en;
    logic       wr_auto;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       clear;
    logic       wr_ready;
    logic [2:0] wr_ptr;

    modport master (
        output wr_en, wr_auto, wr_addr, wr_data, clear,
        input  wr_ready, wr_ptr
    );

    modport slave (
        input  wr_en, wr_auto, wr_addr, wr_data, clear,
        output wr_ready, wr_ptr
    );
endinterface

// File: rtl/seg_digit_loader.sv
// Shadow/active digit banks for an 8-digit display; the shadow bank is copied into the
// active bank in one edge, optionally held off until the scanner's frame boundary.
module seg_digit_loader #(
    parameter logic [3:0] BLANK          = 4'hF,
    parameter bit         COMMIT_ON_SYNC = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    seg_digit_loader_if.slave   wr_bus,
    input  logic                commit,
    input  logic                frame_sync,
    output logic                pending,
    output logic                upd_pulse,
    output logic [3:0]          Data0_o,
    output logic [3:0]          Data1_o,
    output logic [3:0]          Data2_o,
    output logic [3:0]          Data3_o,
    output logic [3:0]          Data4_o,
    output logic [3:0]          Data5_o,
    output logic [3:0]          Data6_o,
    output logic [3:0]          Data7_o
);

    logic [3:0] shadow_q [8];
    logic [3:0] shadow_d [8];
    logic [3:0] active_q [8];
    logic [3:0] active_d [8];
    logic [2:0] wr_ptr_q, wr_ptr_d;
    logic       pending_q, pending_d;
    logic       upd_pulse_q, upd_pulse_d;

    logic       xfer;
    logic       wr_fire;
    logic       clear_fire;
    logic [2:0] wr_idx;

    // With sync gating, a commit that coincides with frame_sync transfers at once.
    assign xfer       = COMMIT_ON_SYNC ? (frame_sync & (pending_q | commit)) : commit;
    assign wr_fire    = wr_bus.wr_en & ~pending_q;
    assign clear_fire = wr_bus.clear & ~pending_q;
    assign wr_idx     = wr_bus.wr_auto ? wr_ptr_q : wr_bus.wr_addr;

    always_comb begin
        shadow_d    = shadow_q;
        active_d    = active_q;
        wr_ptr_d    = wr_ptr_q;
        pending_d   = pending_q;
        upd_pulse_d = xfer;

        if (clear_fire) begin
            for (int i = 0; i < 8; i++) begin
                shadow_d[i] = BLANK;
            end
            wr_ptr_d = 3'd0;
        end else if (wr_fire) begin
            shadow_d[wr_idx] = wr_bus.wr_data;
            wr_ptr_d         = wr_idx + 3'd1;
        end

        // Active takes the pre-write shadow; pointer reset wins over the increment.
        if (xfer) begin
            active_d  = shadow_q;
            wr_ptr_d  = 3'd0;
            pending_d = 1'b0;
        end else if (COMMIT_ON_SYNC && commit && !pending_q) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q    <= '{default: BLANK};
            active_q    <= '{default: BLANK};
            wr_ptr_q    <= 3'd0;
            pending_q   <= 1'b0;
            upd_pulse_q <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            wr_ptr_q    <= wr_ptr_d;
            pending_q   <= pending_d;
            upd_pulse_q <= upd_pulse_d;
        end
    end

    assign wr_bus.wr_ready = ~pending_q;
    assign wr_bus.wr_ptr   = wr_ptr_q;
    assign pending         = pending_q;
    assign upd_pulse       = upd_pulse_q;

    assign Data0_o = active_q[0];
    assign Data1_o = active_q[1];
    assign Data2_o = active_q[2];
    assign Data3_o = active_q[3];
    assign Data4_o = active_q[4];
    assign Data5_o = active_q[5];
    assign Data6_o = active_q[6];
    assign Data7_o = active_q[7];

endmodule
